// File: rtl/lut_request_arbiter.sv
// Round-robin arbiter multiplexing N client lookup requests onto one lut_master port.
// Optional watchdog enabled by defining LUT_ARB_TIMEOUT_EN.
module lut_request_arbiter #(
    parameter int unsigned n_clients      = 4,
    parameter int unsigned data_width     = 16,
    parameter int unsigned handle_width   = 2,
    parameter int unsigned timeout_cycles = 256
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [n_clients-1:0]               cl_req,
    input  logic [n_clients*handle_width-1:0]  cl_handle,
    input  logic [n_clients*data_width-1:0]    cl_arg,
    output logic [n_clients-1:0]               cl_grant,
    output logic [data_width-1:0]              cl_data,
    output logic [n_clients-1:0]               cl_valid,
    output logic [n_clients-1:0]               cl_error,
    output logic                               lut_req,
    output logic [handle_width-1:0]            lut_handle,
    output logic [data_width-1:0]              lut_arg,
    input  logic [data_width-1:0]              lut_data,
    input  logic                               lut_ready,
    input  logic                               lut_invalid,
    output logic                               lut_fault
);

    localparam int unsigned IW = (n_clients > 1) ? $clog2(n_clients) : 1;

    if (n_clients < 2 || timeout_cycles < 1) begin : g_bad_params
        $error("lut_request_arbiter: n_clients must be >= 2 and timeout_cycles >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_ERROR} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [n_clients-1:0]    cl_grant_q, cl_grant_d;
    logic [n_clients-1:0]    cl_valid_q, cl_valid_d;
    logic [n_clients-1:0]    cl_error_q, cl_error_d;
    logic [data_width-1:0]   cl_data_q, cl_data_d;
    logic                    lut_req_q, lut_req_d;
    logic [handle_width-1:0] lut_handle_q, lut_handle_d;
    logic [data_width-1:0]   lut_arg_q, lut_arg_d;
    logic                    lut_fault_q, lut_fault_d;

    logic                    win_found;
    logic [IW-1:0]           win_idx;
    int unsigned             scan_j;
    logic                    do_grant, busy_ack, fail_inv, done_ok, timeout_hit, do_fail;

    // First requester at or after rr_ptr, wrapping modulo n_clients.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_j    = 0;
        for (int unsigned k = 0; k < n_clients; k++) begin
            scan_j = (32'(rr_ptr_q) + k) % n_clients;
            if (!win_found && cl_req[scan_j]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_j);
            end
        end
    end

    always_comb begin
        do_grant = (state_q == S_IDLE) && lut_ready && win_found;
        busy_ack = (state_q == S_WAIT_BUSY) && !lut_ready;
        fail_inv = (state_q == S_WAIT_DONE) && lut_invalid;
        done_ok  = (state_q == S_WAIT_DONE) && !lut_invalid && lut_ready;
        do_fail  = fail_inv || timeout_hit;
    end

`ifdef LUT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(timeout_cycles + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          in_wait;

    always_comb begin
        in_wait  = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
        wd_cnt_d = wd_cnt_q;
        if (do_grant)
            wd_cnt_d = '0;
        else if (in_wait)
            wd_cnt_d = wd_cnt_q + CW'(1);
        // Master handshake in the same cycle wins over the watchdog.
        timeout_hit = in_wait && !busy_ack && !fail_inv && !done_ok
                      && (wd_cnt_q == CW'(timeout_cycles - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
    end
`else
    always_comb timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (do_grant) state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (timeout_hit) state_d = S_ERROR;
                         else if (busy_ack) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (do_fail) state_d = S_ERROR;
                         else if (done_ok) state_d = S_IDLE;
            S_ERROR:     state_d = S_ERROR;
        endcase
    end

    always_comb begin
        idx_d        = idx_q;
        rr_ptr_d     = rr_ptr_q;
        cl_grant_d   = '0;
        cl_valid_d   = '0;
        cl_error_d   = '0;
        cl_data_d    = cl_data_q;
        lut_req_d    = 1'b0;
        lut_handle_d = lut_handle_q;
        lut_arg_d    = lut_arg_q;
        lut_fault_d  = (state_d == S_ERROR);
        if (do_grant) begin
            idx_d               = win_idx;
            cl_grant_d[win_idx] = 1'b1;
            lut_req_d           = 1'b1;
            lut_handle_d        = cl_handle[32'(win_idx)*handle_width +: handle_width];
            lut_arg_d           = cl_arg[32'(win_idx)*data_width +: data_width];
        end
        if (do_fail) begin
            cl_error_d[idx_q] = 1'b1;
        end else if (done_ok) begin
            cl_data_d         = lut_data;
            cl_valid_d[idx_q] = 1'b1;
            rr_ptr_d          = (idx_q == IW'(n_clients - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= '0;
            rr_ptr_q     <= '0;
            cl_grant_q   <= '0;
            cl_valid_q   <= '0;
            cl_error_q   <= '0;
            cl_data_q    <= '0;
            lut_req_q    <= 1'b0;
            lut_handle_q <= '0;
            lut_arg_q    <= '0;
            lut_fault_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            rr_ptr_q     <= rr_ptr_d;
            cl_grant_q   <= cl_grant_d;
            cl_valid_q   <= cl_valid_d;
            cl_error_q   <= cl_error_d;
            cl_data_q    <= cl_data_d;
            lut_req_q    <= lut_req_d;
            lut_handle_q <= lut_handle_d;
            lut_arg_q    <= lut_arg_d;
            lut_fault_q  <= lut_fault_d;
        end
    end

    assign cl_grant   = cl_grant_q;
    assign cl_valid   = cl_valid_q;
    assign cl_error   = cl_error_q;
    assign cl_data    = cl_data_q;
    assign lut_req    = lut_req_q;
    assign lut_handle = lut_handle_q;
    assign lut_arg    = lut_arg_q;
    assign lut_fault  = lut_fault_q;

endmodule

// File: tb/tb_lut_request_arbiter.sv
// Directed bench for lut_request_arbiter with a small lut_master model and an event scoreboard.
// Timeout expectations follow LUT_ARB_TIMEOUT_EN.
module tb_lut_request_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int HW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    cl_req = '0;
    logic [N*HW-1:0] cl_handle = '0;
    logic [N*DW-1:0] cl_arg = '0;
    logic [N-1:0]    cl_grant, cl_valid, cl_error;
    logic [DW-1:0]   cl_data;
    logic            lut_req;
    logic [HW-1:0]   lut_handle;
    logic [DW-1:0]   lut_arg;
    logic [DW-1:0]   lut_data;
    logic            lut_ready, lut_invalid, lut_fault;

    lut_request_arbiter #(
        .n_clients(N), .data_width(DW), .handle_width(HW), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cl_req(cl_req), .cl_handle(cl_handle), .cl_arg(cl_arg),
        .cl_grant(cl_grant), .cl_data(cl_data), .cl_valid(cl_valid), .cl_error(cl_error),
        .lut_req(lut_req), .lut_handle(lut_handle), .lut_arg(lut_arg),
        .lut_data(lut_data), .lut_ready(lut_ready), .lut_invalid(lut_invalid),
        .lut_fault(lut_fault)
    );

    always #5 clk = ~clk;

    // lut_master model: drops ready on req, answers after m_latency cycles
    int   m_latency = 5;
    bit   m_hang = 0, m_invalid = 0, hold_busy = 0;
    logic m_rdy, m_inv, m_busy;
    int   m_cnt;
    logic [DW-1:0] m_data;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rdy <= 1'b1; m_inv <= 1'b0; m_busy <= 1'b0; m_cnt <= 0; m_data <= '0;
        end else if (lut_req) begin
            m_rdy <= 1'b0; m_inv <= 1'b0; m_busy <= 1'b1; m_cnt <= m_latency;
        end else if (m_busy) begin
            if (m_cnt > 1) m_cnt <= m_cnt - 1;
            else if (!m_hang) begin
                m_busy <= 1'b0;
                if (m_invalid) m_inv <= 1'b1;
                else begin
                    m_rdy  <= 1'b1;
                    m_data <= lut_arg + 16'h3FFF + {14'b0, lut_handle};
                end
            end
        end
    end

    assign lut_ready   = m_rdy && !hold_busy;
    assign lut_invalid = m_inv;
    assign lut_data    = m_data;

    typedef struct {
        int          kind;   // 0 grant, 1 valid, 2 error
        logic [3:0]  vec;
        logic [15:0] data;
        logic [1:0]  hdl;
        logic [15:0] arg;
    } ev_t;

    ev_t sb[$];
    int  errors = 0, checks = 0;
    int  cyc = 0, lut_req_cnt = 0, t_grant = 0, t_err = 0;
    bit  auto_drop = 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] f(input logic [1:0] h, input logic [15:0] a);
        return a + 16'h3FFF + {14'b0, h};
    endfunction

    task automatic push(input int kind, input int client, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.vec  = 4'b0001 << client;
        e.data = data;
        e.hdl  = cl_handle[client*HW +: HW];
        e.arg  = cl_arg[client*DW +: DW];
        sb.push_back(e);
    endtask

    task automatic tick();
        logic [3:0] ovec;
        int         okind;
        ev_t        e;
        @(posedge clk);
        #1;
        cyc++;
        if (lut_req) lut_req_cnt++;
        check("one_pulse", $onehot0({cl_grant, cl_valid, cl_error}), 1);
        if (|{cl_grant, cl_valid, cl_error}) begin
            ovec  = cl_grant | cl_valid | cl_error;
            okind = (cl_grant != 0) ? 0 : (cl_valid != 0) ? 1 : 2;
            check("pulse_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ev_kind", okind, e.kind);
                check("ev_vec", ovec, e.vec);
                if (e.kind == 1) check("cl_data", cl_data, e.data);
                if (e.kind == 0) begin
                    check("lut_req_at_grant", lut_req, 1);
                    check("lut_handle", lut_handle, e.hdl);
                    check("lut_arg", lut_arg, e.arg);
                    t_grant = cyc;
                end
                if (e.kind == 2) t_err = cyc;
            end
        end
        if (auto_drop) cl_req = cl_req & ~cl_grant;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        cl_handle = {2'd2, 2'd3, 2'd0, 2'd1};
        cl_arg    = {16'hC000, 16'h0100, 16'h4000, 16'h1234};
        #1 reset_n = 1'b0;
        #2;
        check("rst_grant", cl_grant, 0);
        check("rst_valid", cl_valid, 0);
        check("rst_error", cl_error, 0);
        check("rst_data", cl_data, 0);
        check("rst_lut_req", lut_req, 0);
        check("rst_handle", lut_handle, 0);
        check("rst_arg", lut_arg, 0);
        check("rst_fault", lut_fault, 0);
        #19 reset_n = 1'b1;
        tick(); tick();

        // single lookup from client 1
        t0 = cyc;
        cl_req = 4'b0010;
        lut_req_cnt = 0;
        push(0, 1, '0);
        push(1, 1, 16'h7FFF);
        drain(40);
        check("single_grant_latency", t_grant - t0, 1);
        check("single_lut_req_pulses", lut_req_cnt, 1);
        tick();
        do_reset();

        // fairness: all clients held for eight lookups
        auto_drop = 0;
        m_latency = 3;
        for (int i = 0; i < 8; i++) begin
            push(0, i % 4, '0);
            push(1, i % 4, f(cl_handle[(i%4)*HW +: HW], cl_arg[(i%4)*DW +: DW]));
        end
        lut_req_cnt = 0;
        cl_req = 4'b1111;
        drain(200);
        cl_req = 4'b0000;
        check("fair_lut_req_pulses", lut_req_cnt, 8);
        auto_drop = 1;
        repeat (3) tick();

        // busy master: no grant while lut_ready is low
        hold_busy = 1;
        cl_req = 4'b0001;
        lut_req_cnt = 0;
        repeat (6) tick();
        check("busy_no_lut_req", lut_req_cnt, 0);
        check("busy_req_still_pending", cl_req, 4'b0001);
        push(0, 0, '0);
        push(1, 0, f(2'd1, 16'h1234));
        hold_busy = 0;
        drain(40);
        check("busy_lut_req_pulses", lut_req_cnt, 1);

        // invalid handle from client 2 -> sticky error
        m_invalid = 1;
        cl_req = 4'b0100;
        push(0, 2, '0);
        push(2, 2, '0);
        drain(40);
        check("invalid_fault", lut_fault, 1);
        cl_req = 4'b1111;
        lut_req_cnt = 0;
        repeat (10) tick();
        check("error_no_lut_req", lut_req_cnt, 0);
        check("error_fault_sticky", lut_fault, 1);
        cl_req = 4'b0000;
        m_invalid = 0;
        do_reset();
        tick();
        check("fault_cleared", lut_fault, 0);

        // hung master
        m_hang = 1;
        cl_req = 4'b1000;
        lut_req_cnt = 0;
        push(0, 3, '0);
`ifdef LUT_ARB_TIMEOUT_EN
        push(2, 3, '0);
        drain(60);
        check("timeout_delay", t_err - t_grant, TO);
        check("timeout_fault", lut_fault, 1);
`else
        drain(10);
        repeat (40) tick();
        check("hang_no_fault", lut_fault, 0);
`endif
        check("hang_lut_req_pulses", lut_req_cnt, 1);
        m_hang = 0;
        do_reset();
        tick();

        // reset during S_WAIT_DONE
        m_latency = 8;
        cl_req = 4'b0100;
        push(0, 2, '0);
        drain(10);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check("abort_grant", cl_grant, 0);
        check("abort_valid", cl_valid, 0);
        check("abort_error", cl_error, 0);
        check("abort_data", cl_data, 0);
        check("abort_lut_req", lut_req, 0);
        check("abort_handle", lut_handle, 0);
        check("abort_arg", lut_arg, 0);
        check("abort_fault", lut_fault, 0);
        #3 reset_n = 1'b1;
        repeat (12) tick();
        cl_req = 4'b0101;
        push(0, 0, '0);
        push(1, 0, f(2'd1, 16'h1234));
        drain(40);
        check("post_abort_pending", cl_req, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
